// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch controller: FSM state encoding and phase counter width.
package sr_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/sr_phase_timer.sv
// Saturating down-counter that times the DRIVE and SETTLE phases.
module sr_phase_timer
  import sr_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             tick,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  // Holds at zero rather than wrapping, so a stray tick can never restart a phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_controller.sv
// Drives set/reset pulses into an external SR latch and verifies its q/q_bar feedback.
module sr_latch_controller
  import sr_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err,
  output logic q_exp
);

  // Timer loads hold (cycles - 1): the loading edge itself starts the first cycle.
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_t           state_q;
  logic             s_q, r_q, busy_q, done_q, err_q, q_exp_q, prio_set_q;
  logic             req_any, grant_set, fb_bad;
  logic             tmr_load, tmr_tick, tmr_expired;
  logic [CNT_W-1:0] tmr_value;

  assign req_any   = set_req | clr_req;
  assign grant_set = set_req & (~clr_req | prio_set_q);
  assign fb_bad    = (q_fb != q_exp_q) || (q_bar_fb == q_exp_q);

  always_comb begin
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        tmr_load  = req_any;
        tmr_value = PULSE_LD;
      end
      ST_DRIVE: begin
        if (tmr_expired) begin
          tmr_load  = (SETTLE_CYCLES != 0);
          tmr_value = SETTLE_LD;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      ST_SETTLE: tmr_tick = ~tmr_expired;
      default: ;
    endcase
  end

  sr_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (tmr_tick),
    .expired    (tmr_expired)
  );

  // Feedback is sampled on the edge entering CHECK so err and done rise together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      q_exp_q    <= 1'b0;
      prio_set_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            state_q <= ST_DRIVE;
            busy_q  <= 1'b1;
            q_exp_q <= grant_set;
            s_q     <= grant_set;
            r_q     <= ~grant_set;
            if (set_req && clr_req) prio_set_q <= ~prio_set_q;
          end
        end
        ST_DRIVE: begin
          if (tmr_expired) begin
            s_q <= 1'b0;
            r_q <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              state_q <= ST_CHECK;
              done_q  <= 1'b1;
              err_q   <= err_q | fb_bad;
            end else begin
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_expired) begin
            state_q <= ST_CHECK;
            done_q  <= 1'b1;
            err_q   <= err_q | fb_bad;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s     = s_q;
  assign r     = r_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign q_exp = q_exp_q;

endmodule

// File: tb/tb_sr_latch_controller.sv
// Directed bench for sr_latch_controller with a clocked SR latch model on the feedback path.
module tb_sr_latch_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0, clr_req = 1'b0;
  logic s, r, busy, done, err, q_exp;
  logic lq, stuck = 1'b0;

  logic set2 = 1'b0, clr2 = 1'b0;
  logic s2, r2, busy2, done2, err2, qexp2;
  logic lq2;

  int cmp = 0;
  int bad = 0;
  int ovl = 0;

  always #5 clk = ~clk;

  sr_latch_controller dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .q_fb(lq), .q_bar_fb(~lq), .s(s), .r(r), .busy(busy),
    .done(done), .err(err), .q_exp(q_exp)
  );

  sr_latch_controller #(.PULSE_CYCLES(15), .SETTLE_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .set_req(set2), .clr_req(clr2),
    .q_fb(lq2), .q_bar_fb(~lq2), .s(s2), .r(r2), .busy(busy2),
    .done(done2), .err(err2), .q_exp(qexp2)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)        lq <= 1'b0;
    else if (stuck) lq <= 1'b0;
    else if (s)     lq <= 1'b1;
    else if (r)     lq <= 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)     lq2 <= 1'b0;
    else if (s2) lq2 <= 1'b1;
    else if (r2) lq2 <= 1'b0;
  end

  always @(posedge clk) if (s && r) ovl <= ovl + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    cmp++; if (s !== 1'b0)     begin bad++; $display("FAIL reset_s got %b want 0", s); end
    cmp++; if (r !== 1'b0)     begin bad++; $display("FAIL reset_r got %b want 0", r); end
    cmp++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    cmp++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got %b want 0", done); end
    cmp++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got %b want 0", err); end
    cmp++; if (q_exp !== 1'b0) begin bad++; $display("FAIL reset_q_exp got %b want 0", q_exp); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_set();
    logic [4:1] s_seen, d_seen;
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    s_seen[1] = s; d_seen[1] = done;
    cmp++; if (q_exp !== 1'b1) begin bad++; $display("FAIL set_q_exp got %b want 1", q_exp); end
    for (int c = 2; c <= 4; c++) begin
      step();
      s_seen[c] = s; d_seen[c] = done;
    end
    cmp++; if (s_seen !== 4'b0011) begin bad++; $display("FAIL set_s_window got %b want 0011", s_seen); end
    cmp++; if (d_seen !== 4'b1000) begin bad++; $display("FAIL set_done_window got %b want 1000", d_seen); end
    cmp++; if (err !== 1'b0)  begin bad++; $display("FAIL set_err got %b want 0", err); end
    cmp++; if (busy !== 1'b1) begin bad++; $display("FAIL set_busy_check got %b want 1", busy); end
    step();
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL set_busy_idle got %b want 0", busy); end
    cmp++; if (done !== 1'b0) begin bad++; $display("FAIL set_done_drop got %b want 0", done); end
  endtask

  task automatic test_tie();
    int n;
    set_req = 1'b1; clr_req = 1'b1;
    step();
    set_req = 1'b0; clr_req = 1'b0;
    cmp++; if ({s, r} !== 2'b10) begin bad++; $display("FAIL tie1_sr got %b want 10", {s, r}); end
    wait_done(10, n);
    cmp++; if (n >= 10) begin bad++; $display("FAIL tie1_done got timeout want done"); end
    step();
    set_req = 1'b1; clr_req = 1'b1;
    step();
    set_req = 1'b0; clr_req = 1'b0;
    cmp++; if ({s, r} !== 2'b01) begin bad++; $display("FAIL tie2_sr got %b want 01", {s, r}); end
    cmp++; if (q_exp !== 1'b0) begin bad++; $display("FAIL tie2_q_exp got %b want 0", q_exp); end
    wait_done(10, n);
    cmp++; if (n >= 10) begin bad++; $display("FAIL tie2_done got timeout want done"); end
    step();
    cmp++; if (ovl !== 0) begin bad++; $display("FAIL tie_overlap got %0d want 0", ovl); end
  endtask

  task automatic test_busy_ignore();
    int dcnt = 0, rcnt = 0;
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    clr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 3) clr_req = 1'b0;
      if (done) dcnt++;
      if (r) rcnt++;
    end
    clr_req = 1'b0;
    cmp++; if (dcnt !== 1) begin bad++; $display("FAIL busy_done_count got %0d want 1", dcnt); end
    cmp++; if (rcnt !== 0) begin bad++; $display("FAIL busy_r_count got %0d want 0", rcnt); end
    cmp++; if (q_exp !== 1'b1) begin bad++; $display("FAIL busy_q_exp got %b want 1", q_exp); end
  endtask

  task automatic test_stuck();
    int n;
    stuck = 1'b1;
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    wait_done(10, n);
    cmp++; if (n >= 10) begin bad++; $display("FAIL stuck_done got timeout want done"); end
    cmp++; if (err !== 1'b1) begin bad++; $display("FAIL stuck_err got %b want 1", err); end
    step();
    stuck = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_done(10, n);
    cmp++; if (n >= 10) begin bad++; $display("FAIL stuck_clear_done got timeout want done"); end
    cmp++; if (q_exp !== 1'b0) begin bad++; $display("FAIL stuck_clear_q_exp got %b want 0", q_exp); end
    step();
    cmp++; if (err !== 1'b1) begin bad++; $display("FAIL stuck_err_sticky got %b want 1", err); end
  endtask

  task automatic test_rst_mid();
    int n, dcnt = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err_clear got %b want 0", err); end
    set_req = 1'b1; clr_req = 1'b1;
    step();
    set_req = 1'b0; clr_req = 1'b0;
    wait_done(10, n);
    step();
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    cmp++; if (s !== 1'b1) begin bad++; $display("FAIL rst_pre_s got %b want 1", s); end
    #2 rst = 1'b1;
    #1;
    cmp++; if (s !== 1'b0)     begin bad++; $display("FAIL rst_mid_s got %b want 0", s); end
    cmp++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    cmp++; if (q_exp !== 1'b0) begin bad++; $display("FAIL rst_mid_q_exp got %b want 0", q_exp); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dcnt++;
    end
    cmp++; if (dcnt !== 0) begin bad++; $display("FAIL rst_no_done got %0d want 0", dcnt); end
    set_req = 1'b1; clr_req = 1'b1;
    step();
    set_req = 1'b0; clr_req = 1'b0;
    cmp++; if ({s, r} !== 2'b10) begin bad++; $display("FAIL rst_prio_sr got %b want 10", {s, r}); end
    wait_done(10, n);
    step();
  endtask

  task automatic test_long_pulse();
    int n = 1, scnt = 0;
    set2 = 1'b1;
    step();
    set2 = 1'b0;
    while (!done2 && n < 40) begin
      if (s2) scnt++;
      step();
      n++;
    end
    cmp++; if (n !== 16)    begin bad++; $display("FAIL long_latency got %0d want 16", n); end
    cmp++; if (scnt !== 15) begin bad++; $display("FAIL long_s_cycles got %0d want 15", scnt); end
    cmp++; if (err2 !== 1'b0)  begin bad++; $display("FAIL long_err got %b want 0", err2); end
    cmp++; if (qexp2 !== 1'b1) begin bad++; $display("FAIL long_q_exp got %b want 1", qexp2); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_tie();
    test_busy_ignore();
    test_stuck();
    test_rst_mid();
    test_long_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
